bcd_time_keeper: RTL and testbench
==================================

# bcd_time_keeper

Parametrised BCD time-of-day counter: the next-generation timekeeping core of the alarm clock. It adds optional seconds, runtime 12/24-hour display, validated loads, set-mode increment inputs and carry pulses for downstream alarm/chime logic. Time is always held internally in 24-hour BCD. The display outputs are derived from that state and presented in the format selected by `mode_12h`.

## Interface
Parameters:
- `SECONDS_EN`, default 1: 1 = seconds digits present and `tick` advances seconds; 0 = `tick` advances minutes, seconds logic absent.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: reset is synchronous and active-high.
- `tick` input 1: one-cycle advance strobe.
- `load_new` input 1: load `new_*` digits.
- `new_ms_hr`, `new_ls_hr`, `new_ms_min`, `new_ls_min`, `new_ms_sec`, `new_ls_sec` input 4 each: BCD load value. Sec digits are ignored when `SECONDS_EN`=0.
- `new_pm` input 1: PM flag for the load value; used only when `mode_12h`=1.
- `inc_hr`, `inc_min` input 1: set-mode increments, one step per asserted cycle.
- `mode_12h` input 1: 0 = 24-hour format, 1 = 12-hour format for display and load.
- `ms_hr`, `ls_hr`, `ms_min`, `ls_min`, `ms_sec`, `ls_sec` output 4 each: displayed BCD time. Sec outputs are constant 0 when `SECONDS_EN`=0.
- `pm` output 1: 1 when internal hour ≥12 and `mode_12h`=1; otherwise 0.
- `minute_pulse`, `hour_pulse`, `day_wrap` output 1: registered one-cycle carry pulses.
- `load_err` output 1: registered one-cycle pulse marking a rejected load.

## Operation
- Internal state: 24-hour BCD hours 00–23, minutes 00–59, seconds 00–59.
- Per-cycle priority: `reset` > `load_new` > (`inc_hr`/`inc_min`) > `tick`.
- Tick advance, SECONDS_EN=1:
  - ls_sec increments and wraps 9→0, carrying into ms_sec.
  - ms_sec wraps 5→0, carrying into minutes.
  - Minutes follow the same digit rules and carry into hours.
  - ls_hr wraps 9→0 and carries into ms_hr.
  - 23:59:59 → 00:00:00.
- Tick advance, SECONDS_EN=0: same chain starting at ls_min; 23:59 → 00:00.
- `inc_min`:
  - Minutes advance +1 modulo 60; no carry into hours.
  - Seconds are cleared to 00.
- `inc_hr`: hours advance +1 modulo 24; minutes and seconds unchanged.
- Both `inc_*` in the same cycle: both apply. A `tick` in that cycle is discarded.
- Load validation (per-digit ≤9 and range checks):
  - 24h mode: hours 00–23, minutes 00–59, seconds 00–59.
  - 12h mode: hours 01–12, same minute and second ranges.
- 12h load conversion:
  - 12 AM → 00.
  - 1–11 AM unchanged.
  - 12 PM → 12.
  - 1–11 PM → +12.
- Invalid load: state unchanged; `load_err`=1 for one cycle. `inc_*` and `tick` in that cycle are still discarded.
- Display mapping is combinational from state and `mode_12h`:
  - 24h mode: state shown directly, `pm`=0.
  - 12h mode: hour 00 → 12 AM; 01–11 → AM; 12 → 12 PM; 13–23 → minus 12, PM.
- Carry pulses fire only on tick-driven carries, never on load or inc:
  - `minute_pulse`: seconds wrapped 59→00. With SECONDS_EN=0, it fires on every accepted tick.
  - `hour_pulse`: minutes wrapped 59→00.
  - `day_wrap`: hours wrapped 23→00.

## Timing
- Reset values:
  - Internal state 00:00:00.
  - All pulse outputs 0.
  - Display in 24h mode: 00:00:00, `pm`=0.
  - Display in 12h mode: 12:00:00, `pm`=0.
- Latency: an input sampled at edge N produces the new state and display at edge N; the value is visible during cycle N+1.
- Pulses assert during the same cycle N+1 as the updated time and last exactly one cycle.
- Reset asserted mid-operation: state and pulses cleared at that edge; all other inputs in that cycle are ignored.
- `mode_12h` toggling changes only the display, immediately (combinational); stored time is never altered.
- Back-to-back ticks on consecutive cycles: each one advances the time; there is no minimum spacing.
- Held `inc_*` inputs advance the time once per cycle.

## Test plan
- Reset, then `tick` ×60 with SECONDS_EN=1 → time 00:01:00; `minute_pulse` high only in the cycle after tick 60; `hour_pulse`=0.
- Load 23:59:59 (24h), then one `tick` → 00:00:00; `minute_pulse`, `hour_pulse` and `day_wrap` all high for one cycle. A further tick → 00:00:01 with no pulses.
- `mode_12h`=1, load 12:30:00 `new_pm`=0 → internal 00:30:00, display 12:30:00 `pm`=0. Load 01:05:00 `new_pm`=1 → internal 13:05:00, display 01:05:00 `pm`=1.
- Invalid loads → state unchanged and one-cycle `load_err`:
  - 24h mode: 24:00:00, 12:60:00 and 0A:00:00.
  - 12h mode: 00:15:00 and 13:00:00.
- From 10:59:42: `inc_min` → 10:00:00, no `hour_pulse`. Then `inc_hr` with `tick` in the same cycle → 11:00:00, tick discarded. From 23:xx, `inc_hr` → 00:xx with no `day_wrap`.
- SECONDS_EN=0: load 09:59, one `tick` → 10:00, with `minute_pulse` and `hour_pulse` high and sec outputs 0. `load_new` and `tick` together → loaded value, no advance.

Source files
------------

// File: rtl/bcd_time_keeper.sv
// BCD time-of-day core: 24-hour BCD state, validated loads, set-mode increments,
// tick-driven carry chain with registered carry pulses, and 12/24-hour display mapping.
module bcd_time_keeper #(
  parameter int SECONDS_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load_new,
  input  logic [3:0] new_ms_hr,
  input  logic [3:0] new_ls_hr,
  input  logic [3:0] new_ms_min,
  input  logic [3:0] new_ls_min,
  input  logic [3:0] new_ms_sec,
  input  logic [3:0] new_ls_sec,
  input  logic       new_pm,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       mode_12h,
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min,
  output logic [3:0] ms_sec,
  output logic [3:0] ls_sec,
  output logic       pm,
  output logic       minute_pulse,
  output logic       hour_pulse,
  output logic       day_wrap,
  output logic       load_err
);

  // Each 8-bit field holds {tens, ones} BCD digits; hours are always 24-hour.
  logic [7:0] hr_q, hr_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       minute_pulse_q, minute_pulse_d;
  logic       hour_pulse_q, hour_pulse_d;
  logic       day_wrap_q, day_wrap_d;
  logic       load_err_q, load_err_d;

  logic [8:0] sec_nx, min_nx, hr_nx;
  logic       digits_ok, hr24_ok, hr12_ok, load_ok;
  logic [4:0] load_bin, load_base, load_hr24;
  logic [4:0] hr_bin_q, disp_bin;
  logic [7:0] disp_hr;

  // Returns {wrap, tens, ones} for a +1 step modulo 60.
  function automatic logic [8:0] inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) inc60 = 9'h100;
      else                inc60 = {1'b0, v[7:4] + 4'd1, 4'd0};
    end else begin
      inc60 = {1'b0, v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  // Returns {wrap, tens, ones} for a +1 step modulo 24.
  function automatic logic [8:0] inc24(input logic [7:0] v);
    if (v == 8'h23)             inc24 = 9'h100;
    else if (v[3:0] == 4'd9)    inc24 = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                        inc24 = {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [4:0] hr_bin(input logic [7:0] v);
    hr_bin = {1'b0, v[7:4]} * 5'd10 + {1'b0, v[3:0]};
  endfunction

  function automatic logic [7:0] hr_to_bcd(input logic [4:0] h);
    if (h >= 5'd20)      hr_to_bcd = {4'd2, 4'(h - 5'd20)};
    else if (h >= 5'd10) hr_to_bcd = {4'd1, 4'(h - 5'd10)};
    else                 hr_to_bcd = {4'd0, h[3:0]};
  endfunction

  assign sec_nx = inc60(sec_q);
  assign min_nx = inc60(min_q);
  assign hr_nx  = inc24(hr_q);

  // Load validation; seconds digits only matter when seconds exist.
  assign digits_ok = (new_ls_hr <= 4'd9) && (new_ms_min <= 4'd5) && (new_ls_min <= 4'd9) &&
                     ((SECONDS_EN == 0) || ((new_ms_sec <= 4'd5) && (new_ls_sec <= 4'd9)));
  assign hr24_ok   = (new_ms_hr < 4'd2) || ((new_ms_hr == 4'd2) && (new_ls_hr <= 4'd3));
  assign hr12_ok   = ((new_ms_hr == 4'd0) && (new_ls_hr != 4'd0)) ||
                     ((new_ms_hr == 4'd1) && (new_ls_hr <= 4'd2));
  assign load_ok   = digits_ok && (mode_12h ? hr12_ok : hr24_ok);

  // 12 AM maps to 00 and PM adds 12, so 12 PM lands on 12.
  assign load_bin  = hr_bin({new_ms_hr, new_ls_hr});
  assign load_base = (load_bin == 5'd12) ? 5'd0 : load_bin;
  assign load_hr24 = mode_12h ? (new_pm ? load_base + 5'd12 : load_base) : load_bin;

  always_comb begin
    hr_d           = hr_q;
    min_d          = min_q;
    sec_d          = sec_q;
    minute_pulse_d = 1'b0;
    hour_pulse_d   = 1'b0;
    day_wrap_d     = 1'b0;
    load_err_d     = 1'b0;
    if (load_new) begin
      if (load_ok) begin
        hr_d  = hr_to_bcd(load_hr24);
        min_d = {new_ms_min, new_ls_min};
        sec_d = (SECONDS_EN != 0) ? {new_ms_sec, new_ls_sec} : 8'h00;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (inc_hr || inc_min) begin
      if (inc_min) begin
        min_d = min_nx[7:0];
        sec_d = 8'h00;
      end
      if (inc_hr) hr_d = hr_nx[7:0];
    end else if (tick) begin
      if (SECONDS_EN != 0) begin
        sec_d          = sec_nx[7:0];
        minute_pulse_d = sec_nx[8];
      end else begin
        minute_pulse_d = 1'b1;
      end
      if (minute_pulse_d) begin
        min_d        = min_nx[7:0];
        hour_pulse_d = min_nx[8];
      end
      if (hour_pulse_d) begin
        hr_d       = hr_nx[7:0];
        day_wrap_d = hr_nx[8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hr_q           <= 8'h00;
      min_q          <= 8'h00;
      sec_q          <= 8'h00;
      minute_pulse_q <= 1'b0;
      hour_pulse_q   <= 1'b0;
      day_wrap_q     <= 1'b0;
      load_err_q     <= 1'b0;
    end else begin
      hr_q           <= hr_d;
      min_q          <= min_d;
      sec_q          <= sec_d;
      minute_pulse_q <= minute_pulse_d;
      hour_pulse_q   <= hour_pulse_d;
      day_wrap_q     <= day_wrap_d;
      load_err_q     <= load_err_d;
    end
  end

  // Display: hour 00 shows as 12 AM, 13-23 fold down by 12 in 12-hour mode.
  assign hr_bin_q = hr_bin(hr_q);
  always_comb begin
    disp_bin = hr_bin_q;
    if (mode_12h) begin
      if (hr_bin_q == 5'd0)      disp_bin = 5'd12;
      else if (hr_bin_q > 5'd12) disp_bin = hr_bin_q - 5'd12;
    end
  end
  assign disp_hr = hr_to_bcd(disp_bin);

  assign ms_hr        = disp_hr[7:4];
  assign ls_hr        = disp_hr[3:0];
  assign ms_min       = min_q[7:4];
  assign ls_min       = min_q[3:0];
  assign ms_sec       = sec_q[7:4];
  assign ls_sec       = sec_q[3:0];
  assign pm           = mode_12h && (hr_bin_q >= 5'd12);
  assign minute_pulse = minute_pulse_q;
  assign hour_pulse   = hour_pulse_q;
  assign day_wrap     = day_wrap_q;
  assign load_err     = load_err_q;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Directed bench for bcd_time_keeper: one instance with seconds, one without,
// sharing stimulus; expected times are hand-written BCD constants.
module tb_bcd_time_keeper;

  logic       clk = 1'b0;
  logic       reset, tick, load_new, new_pm, inc_hr, inc_min, mode_12h;
  logic [3:0] new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, new_ms_sec, new_ls_sec;

  logic [3:0] a_ms_hr, a_ls_hr, a_ms_min, a_ls_min, a_ms_sec, a_ls_sec;
  logic       a_pm, a_mp, a_hp, a_dw, a_err;
  logic [3:0] b_ms_hr, b_ls_hr, b_ms_min, b_ls_min, b_ms_sec, b_ls_sec;
  logic       b_pm, b_mp, b_hp, b_dw, b_err;

  logic [23:0] a_time, b_time;
  assign a_time = {a_ms_hr, a_ls_hr, a_ms_min, a_ls_min, a_ms_sec, a_ls_sec};
  assign b_time = {b_ms_hr, b_ls_hr, b_ms_min, b_ls_min, b_ms_sec, b_ls_sec};

  int n_tests = 0;
  int n_fail  = 0;

  bcd_time_keeper #(.SECONDS_EN(1)) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .load_new(load_new),
    .new_ms_hr(new_ms_hr), .new_ls_hr(new_ls_hr), .new_ms_min(new_ms_min),
    .new_ls_min(new_ls_min), .new_ms_sec(new_ms_sec), .new_ls_sec(new_ls_sec),
    .new_pm(new_pm), .inc_hr(inc_hr), .inc_min(inc_min), .mode_12h(mode_12h),
    .ms_hr(a_ms_hr), .ls_hr(a_ls_hr), .ms_min(a_ms_min), .ls_min(a_ls_min),
    .ms_sec(a_ms_sec), .ls_sec(a_ls_sec), .pm(a_pm), .minute_pulse(a_mp),
    .hour_pulse(a_hp), .day_wrap(a_dw), .load_err(a_err)
  );

  bcd_time_keeper #(.SECONDS_EN(0)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .load_new(load_new),
    .new_ms_hr(new_ms_hr), .new_ls_hr(new_ls_hr), .new_ms_min(new_ms_min),
    .new_ls_min(new_ls_min), .new_ms_sec(new_ms_sec), .new_ls_sec(new_ls_sec),
    .new_pm(new_pm), .inc_hr(inc_hr), .inc_min(inc_min), .mode_12h(mode_12h),
    .ms_hr(b_ms_hr), .ls_hr(b_ls_hr), .ms_min(b_ms_min), .ls_min(b_ls_min),
    .ms_sec(b_ms_sec), .ls_sec(b_ls_sec), .pm(b_pm), .minute_pulse(b_mp),
    .hour_pulse(b_hp), .day_wrap(b_dw), .load_err(b_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are applied before the edge; outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [23:0] t, input logic p);
    {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, new_ms_sec, new_ls_sec} = t;
    new_pm   = p;
    load_new = 1'b1;
    cyc();
    load_new = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic pulses_a(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, a_mp, a_hp, a_dw}, {29'd0, exp});
  endtask

  logic mp_early;

  initial begin
    reset = 1'b1; tick = 1'b0; load_new = 1'b0; new_pm = 1'b0;
    inc_hr = 1'b0; inc_min = 1'b0; mode_12h = 1'b0;
    {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, new_ms_sec, new_ls_sec} = 24'h0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state in both display modes
    check("reset_time_24h", a_time, 24'h000000);
    check("reset_pm_24h", a_pm, 0);
    check("reset_flags", {a_mp, a_hp, a_dw, a_err}, 4'b0000);
    mode_12h = 1'b1; #1;
    check("reset_time_12h", a_time, 24'h120000);
    check("reset_pm_12h", a_pm, 0);
    mode_12h = 1'b0; #1;

    // 60 back-to-back ticks roll into the first minute
    mp_early = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick = 1'b1;
      cyc();
      if (i < 60) mp_early = mp_early | a_mp;
    end
    tick = 1'b0;
    check("tick60_early_mp", mp_early, 0);
    check("tick60_time", a_time, 24'h000100);
    pulses_a("tick60_pulses", 3'b100);
    cyc();
    pulses_a("tick60_mp_one_cycle", 3'b000);

    // Day wrap
    do_load(24'h235959, 1'b0);
    check("load_235959", a_time, 24'h235959);
    check("load_no_err", a_err, 0);
    pulses_a("load_no_pulses", 3'b000);
    do_tick();
    check("daywrap_time", a_time, 24'h000000);
    pulses_a("daywrap_pulses", 3'b111);
    do_tick();
    check("after_wrap_time", a_time, 24'h000001);
    pulses_a("after_wrap_pulses", 3'b000);

    // 12-hour loads and display
    mode_12h = 1'b1;
    do_load(24'h123000, 1'b0);
    check("l12_1230am_disp", a_time, 24'h123000);
    check("l12_1230am_pm", a_pm, 0);
    mode_12h = 1'b0; #1;
    check("l12_1230am_int", a_time, 24'h003000);
    mode_12h = 1'b1;
    do_load(24'h010500, 1'b1);
    check("l12_0105pm_disp", a_time, 24'h010500);
    check("l12_0105pm_pm", a_pm, 1);
    mode_12h = 1'b0; #1;
    check("l12_0105pm_int", a_time, 24'h130500);
    check("l12_pm_hidden_24h", a_pm, 0);

    // Rejected loads: 24-hour mode
    do_load(24'h240000, 1'b0);
    check("bad_24_err", a_err, 1);
    check("bad_24_time", a_time, 24'h130500);
    cyc();
    check("bad_24_err_one_cycle", a_err, 0);
    do_load(24'h126000, 1'b0);
    check("bad_60min_err", a_err, 1);
    check("bad_60min_time", a_time, 24'h130500);
    do_load(24'h0A0000, 1'b0);
    check("bad_0A_err", a_err, 1);
    check("bad_0A_time", a_time, 24'h130500);
    // Rejected loads: 12-hour mode, with a tick and inc held in the same cycle
    mode_12h = 1'b1;
    tick = 1'b1; inc_min = 1'b1;
    do_load(24'h001500, 1'b0);
    tick = 1'b0; inc_min = 1'b0;
    check("bad12_00_err", a_err, 1);
    check("bad12_00_time", a_time, 24'h010500);
    do_load(24'h130000, 1'b1);
    check("bad12_13_err", a_err, 1);
    check("bad12_13_time", a_time, 24'h010500);
    check("bad12_13_pm", a_pm, 1);
    mode_12h = 1'b0;

    // Set-mode increments
    do_load(24'h105942, 1'b0);
    inc_min = 1'b1; cyc(); inc_min = 1'b0;
    check("inc_min_time", a_time, 24'h100000);
    pulses_a("inc_min_pulses", 3'b000);
    inc_hr = 1'b1; tick = 1'b1; cyc(); inc_hr = 1'b0; tick = 1'b0;
    check("inc_hr_tick_time", a_time, 24'h110000);
    pulses_a("inc_hr_tick_pulses", 3'b000);
    do_load(24'h231705, 1'b0);
    inc_hr = 1'b1; cyc(); inc_hr = 1'b0;
    check("inc_hr_wrap_time", a_time, 24'h001705);
    pulses_a("inc_hr_wrap_pulses", 3'b000);
    inc_hr = 1'b1; inc_min = 1'b1; cyc(); cyc(); inc_hr = 1'b0; inc_min = 1'b0;
    check("inc_both_held_time", a_time, 24'h021900);

    // Reset wins over a simultaneous tick
    reset = 1'b1; tick = 1'b1; cyc(); reset = 1'b0; tick = 1'b0;
    check("reset_mid_time", a_time, 24'h000000);
    check("reset_mid_b_time", b_time, 24'h000000);

    // No-seconds instance
    do_load(24'h095937, 1'b0);
    check("nosec_load", b_time, 24'h095900);
    do_tick();
    check("nosec_tick_time", b_time, 24'h100000);
    check("nosec_tick_pulses", {b_mp, b_hp, b_dw}, 3'b110);
    check("nosec_sec_zero", {b_ms_sec, b_ls_sec}, 8'h00);
    do_tick();
    check("nosec_mp_every_tick", {b_mp, b_hp, b_dw}, 3'b100);
    check("nosec_tick2_time", b_time, 24'h100100);
    tick = 1'b1;
    do_load(24'h123400, 1'b0);
    tick = 1'b0;
    check("nosec_load_tick_time", b_time, 24'h123400);
    check("nosec_load_tick_pulses", {b_mp, b_hp, b_dw}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
